// File: rtl/sine_nco_pkg.sv
// Shared widths, midscale constant and quadrant helpers for the sine NCO.
package sine_pkg;

   localparam int PHASE_W_DEF = 32;
   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 32;

   localparam logic [DATA_W_DEF-1:0] MIDSCALE =
      {1'b1, {(DATA_W_DEF-1){1'b0}}};

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quad_t;

   // Odd quadrants walk the quarter-wave table backwards.
   function automatic logic [ADDR_W_DEF-1:0] rom_addr(
      input quad_t                 q,
      input logic [ADDR_W_DEF-1:0] idx
   );
      unique case (q)
         Q1, Q3:  rom_addr = ~idx;
         default: rom_addr = idx;
      endcase
   endfunction

endpackage

// File: rtl/sine_nco_phase_accumulator.sv
// Phase accumulator with shadowed frequency word applied on carry-out.
module phase_accumulator #(
   parameter int PHASE_W = 32,
   parameter int OUT_W   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   input  logic [PHASE_W-1:0] i_fcw,
   input  logic               i_fcw_load,
   input  logic               i_phase_rst,
   output logic [OUT_W-1:0]   o_phase_msb,
   output logic               o_wrap,
   output logic               o_fcw_pending
);

   logic [PHASE_W-1:0] r_phase;
   logic [PHASE_W-1:0] r_fcw;
   logic [PHASE_W-1:0] r_shadow;
   logic               r_pending;
   logic               r_wrap;
   logic [PHASE_W:0]   w_sum;
   logic               w_carry;
   logic               w_apply;

   assign w_sum   = {1'b0, r_phase} + {1'b0, r_fcw};
   assign w_carry = i_en & ~i_phase_rst & w_sum[PHASE_W];
   assign w_apply = w_carry | i_phase_rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase   <= '0;
         r_fcw     <= '0;
         r_shadow  <= '0;
         r_pending <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         if (i_phase_rst)
            r_phase <= '0;
         else if (i_en)
            r_phase <= w_sum[PHASE_W-1:0];
         r_wrap <= w_carry;
         if (i_fcw_load)
            r_shadow <= i_fcw;
         // A load landing on the apply edge bypasses the shadow.
         if (w_apply)
            r_fcw <= i_fcw_load ? i_fcw : r_shadow;
         if (w_apply)
            r_pending <= 1'b0;
         else if (i_fcw_load)
            r_pending <= 1'b1;
      end
   end

   assign o_phase_msb   = r_phase[PHASE_W-1 -: OUT_W];
   assign o_wrap        = r_wrap;
   assign o_fcw_pending = r_pending;

endmodule

// File: rtl/sine_nco.sv
// Sine NCO: phase accumulator, quarter-wave ROM addressing, sign rebuild.
module sine_nco
   import sine_pkg::*;
#(
   parameter int PHASE_W = PHASE_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   input  logic [PHASE_W-1:0] i_fcw,
   input  logic               i_fcw_load,
   input  logic               i_phase_rst,
   output logic [ADDR_W-1:0]  o_rom_addr,
   input  logic [DATA_W-1:0]  i_rom_data,
   output logic [DATA_W-1:0]  o_data,
   output logic               o_valid,
   output logic               o_wrap,
   output logic               o_fcw_pending
);

   localparam logic [DATA_W-1:0] MID =
      {1'b1, {(DATA_W-1){1'b0}}};

   logic [ADDR_W+1:0] w_phase;
   quad_t             w_quad;
   logic [ADDR_W-1:0] w_idx;
   logic [DATA_W-1:0] w_mag;
   logic              w_neg;

   logic [ADDR_W-1:0] r_addr;
   quad_t             r_quad1;
   quad_t             r_quad2;
   logic              r_v1;
   logic              r_v2;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;

   phase_accumulator #(
      .PHASE_W (PHASE_W),
      .OUT_W   (ADDR_W + 2)
   ) u_acc (
      .clk           (clk),
      .rst           (rst),
      .i_en          (i_en),
      .i_fcw         (i_fcw),
      .i_fcw_load    (i_fcw_load),
      .i_phase_rst   (i_phase_rst),
      .o_phase_msb   (w_phase),
      .o_wrap        (o_wrap),
      .o_fcw_pending (o_fcw_pending)
   );

   assign w_quad = quad_t'(w_phase[ADDR_W+1 -: 2]);
   assign w_idx  = w_phase[ADDR_W-1:0];
   assign w_mag  = i_rom_data & ~MID;
   assign w_neg  = (r_quad2 == Q2) || (r_quad2 == Q3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_quad1 <= Q0;
         r_quad2 <= Q0;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_data  <= MID;
         r_valid <= 1'b0;
      end else begin
         r_addr  <= rom_addr(w_quad, w_idx);
         r_quad1 <= w_quad;
         r_v1    <= i_en & ~i_phase_rst;
         r_quad2 <= r_quad1;
         r_v2    <= r_v1;
         r_valid <= r_v2;
         // Magnitude is below midscale, so neither branch overflows.
         if (r_v2)
            r_data <= w_neg ? MID - w_mag : MID + w_mag;
      end
   end

   assign o_rom_addr = r_addr;
   assign o_data     = r_data;
   assign o_valid    = r_valid;

endmodule

// File: tb/tb_sine_nco.sv
// Directed self-checking bench for sine_nco with a registered ROM model.
module tb_sine_nco;

   logic        clk;
   logic        rst;
   logic        i_en;
   logic [31:0] i_fcw;
   logic        i_fcw_load;
   logic        i_phase_rst;
   logic [7:0]  o_rom_addr;
   logic [31:0] i_rom_data;
   logic [31:0] o_data;
   logic        o_valid;
   logic        o_wrap;
   logic        o_fcw_pending;

   logic [31:0] rom [256];
   int          checks;
   int          errors;

   sine_nco dut (
      .clk           (clk),
      .rst           (rst),
      .i_en          (i_en),
      .i_fcw         (i_fcw),
      .i_fcw_load    (i_fcw_load),
      .i_phase_rst   (i_phase_rst),
      .o_rom_addr    (o_rom_addr),
      .i_rom_data    (i_rom_data),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .o_wrap        (o_wrap),
      .o_fcw_pending (o_fcw_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) i_rom_data <= rom[o_rom_addr];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [31:0] f);
      i_fcw       = f;
      i_fcw_load  = 1'b1;
      i_phase_rst = 1'b1;
      i_en        = 1'b1;
      step();
      i_fcw_load  = 1'b0;
      i_phase_rst = 1'b0;
   endtask

   function automatic logic [7:0] exp_addr(input int n);
      int q;
      int k;
      q = (n / 256) % 4;
      k = n % 256;
      return (q % 2 == 1) ? 8'(255 - k) : 8'(k);
   endfunction

   function automatic logic [31:0] exp_data(input int n);
      int          q;
      logic [31:0] a;
      q = (n / 256) % 4;
      a = {24'd0, exp_addr(n)};
      return (q >= 2) ? 32'h8000_0000 - a : 32'h8000_0000 + a;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (o_data !== 32'h8000_0000 || o_valid !== 1'b0 ||
          o_rom_addr !== 8'd0 || o_wrap !== 1'b0 ||
          o_fcw_pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold got d=%h v=%b a=%h w=%b p=%b want 80000000 0 00 0 0",
                  o_data, o_valid, o_rom_addr, o_wrap, o_fcw_pending);
      end
      rst = 1'b0;
      start(32'h0040_0000);
      repeat (10) step();
      checks++;
      if (o_valid !== 1'b1) begin
         errors++;
         $display("FAIL run_valid got %b want 1", o_valid);
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (o_data !== 32'h8000_0000 || o_valid !== 1'b0 ||
          o_rom_addr !== 8'd0 || o_wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_async got d=%h v=%b a=%h w=%b want 80000000 0 00 0",
                  o_data, o_valid, o_rom_addr, o_wrap);
      end
      step();
      step();
      rst  = 1'b0;
      i_en = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++;
         if (o_valid !== (i == 3)) begin
            errors++;
            $display("FAIL rel_valid edge=%0d got %b want %b",
                     i, o_valid, (i == 3));
         end
      end
      checks++;
      if (o_data !== 32'h8000_0000 || o_fcw_pending !== 1'b0) begin
         errors++;
         $display("FAIL rel_first got d=%h p=%b want 80000000 0",
                  o_data, o_fcw_pending);
      end
   endtask

   task automatic test_sweep();
      start(32'h0040_0000);
      for (int i = 1; i <= 2100; i++) begin
         step();
         checks++;
         if (o_rom_addr !== exp_addr(i - 1)) begin
            errors++;
            $display("FAIL sweep_addr edge=%0d got %h want %h",
                     i, o_rom_addr, exp_addr(i - 1));
         end
         checks++;
         if (o_wrap !== (i % 1024 == 0)) begin
            errors++;
            $display("FAIL sweep_wrap edge=%0d got %b want %b",
                     i, o_wrap, (i % 1024 == 0));
         end
         if (i >= 3) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp_data(i - 3)) begin
               errors++;
               $display("FAIL sweep_data edge=%0d got v=%b d=%h want 1 %h",
                        i, o_valid, o_data, exp_data(i - 3));
            end
         end
      end
   endtask

   task automatic test_quad_sign();
      rom[0] = 32'h1234_5678;
      start(32'h8000_0000);
      step();
      step();
      checks++;
      if (o_wrap !== 1'b1) begin
         errors++;
         $display("FAIL sign_wrap got %b want 1", o_wrap);
      end
      step();
      checks++;
      if (o_data !== 32'h9234_5678) begin
         errors++;
         $display("FAIL sign_pos got %h want 92345678", o_data);
      end
      step();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 32'h6DCB_A988) begin
         errors++;
         $display("FAIL sign_neg got v=%b d=%h want 1 6dcba988",
                  o_valid, o_data);
      end
      rom[0] = 32'd0;
   endtask

   task automatic test_fcw_update();
      logic exp_w;
      logic exp_p;
      start(32'h4000_0000);
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i == 5) begin
            i_fcw      = 32'h2000_0000;
            i_fcw_load = 1'b1;
         end else begin
            i_fcw_load = 1'b0;
         end
         exp_w = (i == 4) || (i == 8) || (i == 16);
         exp_p = (i == 6) || (i == 7);
         checks++;
         if (o_wrap !== exp_w || o_fcw_pending !== exp_p) begin
            errors++;
            $display("FAIL fcw edge=%0d got w=%b p=%b want %b %b",
                     i, o_wrap, o_fcw_pending, exp_w, exp_p);
         end
         if (i == 10 || i == 11) begin
            checks++;
            if (o_rom_addr !== ((i == 10) ? 8'd128 : 8'd255)) begin
               errors++;
               $display("FAIL fcw_addr edge=%0d got %h want %h",
                        i, o_rom_addr, (i == 10) ? 8'd128 : 8'd255);
            end
         end
      end
   endtask

   task automatic test_enable_gap();
      logic        ev;
      logic [31:0] ed;
      logic [7:0]  ea;
      start(32'h0040_0000);
      for (int i = 1; i <= 32; i++) begin
         step();
         if (i == 20) i_en = 1'b0;
         if (i == 25) i_en = 1'b1;
         ea = (i <= 21) ? 8'(i - 1) : (i <= 26) ? 8'd20 : 8'(i - 6);
         checks++;
         if (o_rom_addr !== ea) begin
            errors++;
            $display("FAIL gap_addr edge=%0d got %h want %h",
                     i, o_rom_addr, ea);
         end
         if (i >= 3) begin
            ev = (i <= 22) || (i >= 28);
            ed = (i <= 22) ? 32'h8000_0000 + 32'(i - 3) :
                 (i <= 27) ? 32'h8000_0013 :
                             32'h8000_0000 + 32'(i - 8);
            checks++;
            if (o_valid !== ev || o_data !== ed) begin
               errors++;
               $display("FAIL gap_data edge=%0d got v=%b d=%h want %b %h",
                        i, o_valid, o_data, ev, ed);
            end
         end
      end
   endtask

   task automatic test_load_on_phase_rst();
      rom[0] = 32'h00AB_CDEF;
      start(32'h0100_0000);
      checks++;
      if (o_fcw_pending !== 1'b0) begin
         errors++;
         $display("FAIL coin_pending got %b want 0", o_fcw_pending);
      end
      step();
      checks++;
      if (o_rom_addr !== 8'd0) begin
         errors++;
         $display("FAIL coin_addr0 got %h want 00", o_rom_addr);
      end
      step();
      checks++;
      if (o_rom_addr !== 8'd4 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL coin_addr1 got a=%h v=%b want 04 0",
                  o_rom_addr, o_valid);
      end
      step();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 32'h80AB_CDEF) begin
         errors++;
         $display("FAIL coin_first got v=%b d=%h want 1 80abcdef",
                  o_valid, o_data);
      end
      step();
      checks++;
      if (o_data !== 32'h8000_0004) begin
         errors++;
         $display("FAIL coin_second got %h want 80000004", o_data);
      end
      rom[0] = 32'd0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      i_en        = 1'b0;
      i_fcw       = '0;
      i_fcw_load  = 1'b0;
      i_phase_rst = 1'b0;
      for (int k = 0; k < 256; k++) rom[k] = 32'(k);
      test_reset();
      test_sweep();
      test_quad_sign();
      test_fcw_update();
      test_enable_gap();
      test_load_on_phase_rst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sine_nco.md
Name: sine_nco

Overview:
- Numerically controlled oscillator that drives the sine DAC stage.
- Runs a phase accumulator and addresses an external quarter-wave sine magnitude ROM.
- Rebuilds the full wave using quadrant symmetry.
- Delivers 32-bit offset-binary samples plus a valid strobe to the DAC data input every enabled cycle.

Parameters:
- PHASE_W, 32: phase accumulator and frequency control word width.
- ADDR_W, 8: quarter-wave ROM address width (2^ADDR_W entries).
- DATA_W, 32: output sample width. The ROM magnitude is DATA_W-1 bits, zero-extended on the ROM bus.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- i_en  in  1  advance phase and issue one sample per cycle
- i_fcw  in  PHASE_W  frequency control word
- i_fcw_load  in  1  capture i_fcw into shadow register
- i_phase_rst  in  1  synchronous phase zero
- o_rom_addr  out  ADDR_W  registered ROM address
- i_rom_data  in  DATA_W  ROM magnitude, valid 1 cycle after o_rom_addr
- o_data  out  DATA_W  offset-binary sine sample to DAC
- o_valid  out  1  o_data is a new sample this cycle
- o_wrap  out  1  one-cycle pulse on accumulator carry-out
- o_fcw_pending  out  1  shadow FCW waiting to be applied

Behaviour:
- Reset (async): phase=0, active fcw=0, shadow=0, pending=0, o_rom_addr=0, quadrant pipe=0, valid pipe=0, o_data=MIDSCALE (2^(DATA_W-1)), o_valid=0, o_wrap=0.
- P0 accumulator:
  - If i_phase_rst: phase<=0, o_wrap<=0.
  - Else if i_en: {carry,phase}<=phase+fcw_active, and o_wrap<=carry.
  - Otherwise phase holds.
  - Wrap-around is modulo 2^PHASE_W.
- FCW update:
  - i_fcw_load sets shadow<=i_fcw and pending<=1. A second load before application overwrites the shadow.
  - Application happens on the same edge that produces a carry, or on i_phase_rst: fcw_active<=shadow, pending<=0.
  - The current step uses the old fcw.
  - If load and apply coincide on one edge, the newly loaded value is applied directly and pending stays 0.
- P1 address:
  - quad = phase[PHASE_W-1:PHASE_W-2]; idx = phase[PHASE_W-3 -: ADDR_W].
  - o_rom_addr <= (quad==1 || quad==3) ? ~idx : idx.
  - quad1<=quad; v1<=i_en & ~i_phase_rst.
  - Registered every cycle.
- P2 ROM wait: quad2<=quad1, v2<=v1. i_rom_data is valid during P2.
- P3 output:
  - If v2: o_data <= quad2[1] ? MIDSCALE - mag : MIDSCALE + mag, with mag = i_rom_data[DATA_W-2:0].
  - If ~v2: o_data holds.
  - o_valid<=v2.
  - No overflow is possible: the result range is 1..2^DATA_W-1.
- Latency: phase value at cycle t produces o_data/o_valid at t+3.
- i_en low: phase frozen. The pipeline drains, with o_valid low 3 cycles after en falls and o_data holding the last sample. Resuming continues phase-continuously.
- Mirror boundary: the peak/zero entries repeat across quadrant edges (addr 255,255 and 0,0). This is intended; the ROM content is sized for it.
- rst mid-operation: all state cleared immediately. The first sample after release is at phase 0 (MIDSCALE+rom[0]).

Decomposition:
- Package sine_pkg: PHASE_W/ADDR_W/DATA_W defaults, MIDSCALE constant, quadrant typedef (Q0..Q3), and a function mapping quadrant+idx to ROM address.
- One natural sub-module, phase_accumulator. It covers the accumulator, shadow FCW, pending logic and wrap pulse.
- The address/sign pipeline stays in the top module.

Test Plan:
- Reset during running (fcw=2^22) -> same cycle: o_data=32'h8000_0000, o_valid=0, o_rom_addr=0, o_wrap=0. After release with en=1, first o_valid on 3rd edge.
- fcw=2^22, en=1, ROM model rom[k]=k -> o_rom_addr runs 0..255, then 255..0, then 0..255, then 255..0. o_data=0x80000000+k in Q0/Q1 and 0x80000000-k in Q2/Q3. o_wrap every 1024 cycles.
- Quadrant sign: phase driven to 0x80000000 (fcw=2^31, two steps), rom[0]=0x12345678 -> o_data=0x6DCBA988.
- fcw=2^30 running, load 2^29 two cycles after wrap -> pending=1. Step stays 2^30 until next o_wrap, then doubles period to 8 cycles. pending clears on the wrap edge.
- en low 5 cycles mid-wave -> phase frozen, o_valid low from the 3rd cycle, o_data holds. After en high, the sample sequence is contiguous with no skipped address.
- i_phase_rst and i_fcw_load on the same edge (value 2^24) -> phase=0, fcw_active=2^24, pending=0. The next o_valid sample is MIDSCALE+rom[0].
